// File: rtl/input_reg_ctrl.sv
// Producer side of the CPU input register: debounced buttons and a gravity timer
// become one-at-a-time move flags in in_reg_data[2:0], cleared by CPU write-back.
module input_reg_ctrl #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int GRAVITY_CYCLES  = 1000,
    parameter int FIFO_DEPTH      = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          btn_down,
    input  logic                          btn_left,
    input  logic                          btn_right,
    input  logic                          gravity_en,
    input  logic                          final_isMoveOrWriteShape,
    input  logic [31:0]                   input_reg_update,
    output logic [31:0]                   in_reg_data,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          event_dropped
);

    localparam int DB_W  = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int GR_W  = $clog2(GRAVITY_CYCLES);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [2:0]        r_sync1;
    logic [2:0]        r_sync2;
    logic [2:0]        r_db_state;
    logic [DB_W-1:0]   r_db_cnt [3];
    logic [2:0]        r_btn_evt;
    logic [GR_W-1:0]   r_grav_cnt;
    logic [2:0]        r_pend;
    logic              r_dropped;
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic [2:0]        r_mem [FIFO_DEPTH];
    logic [31:0]       r_in_reg;

    logic              w_grav_evt;
    logic [2:0]        w_evt;
    logic              w_full;
    logic              w_empty;
    logic [2:0]        w_push_sel;
    logic              w_push;
    logic              w_pop;
    logic              w_drop;

    // Bit order throughout: [0]=down, [1]=left, [2]=right
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync1    <= '0;
            r_sync2    <= '0;
            r_db_state <= '0;
            r_btn_evt  <= '0;
            for (int i = 0; i < 3; i++) r_db_cnt[i] <= '0;
        end else begin
            r_sync1   <= {btn_right, btn_left, btn_down};
            r_sync2   <= r_sync1;
            r_btn_evt <= '0;
            for (int i = 0; i < 3; i++) begin
                if (r_sync2[i] == r_db_state[i]) begin
                    r_db_cnt[i] <= '0;
                end else if (r_db_cnt[i] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                    r_db_state[i] <= ~r_db_state[i];
                    r_db_cnt[i]   <= '0;
                    r_btn_evt[i]  <= ~r_db_state[i];
                end else begin
                    r_db_cnt[i] <= r_db_cnt[i] + 1'b1;
                end
            end
        end
    end

    assign w_grav_evt = gravity_en && (r_grav_cnt == GR_W'(GRAVITY_CYCLES - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_grav_cnt <= '0;
        end else if (!gravity_en || w_grav_evt) begin
            r_grav_cnt <= '0;
        end else begin
            r_grav_cnt <= r_grav_cnt + 1'b1;
        end
    end

    // Gravity and a button down in the same cycle collapse into a single down event
    assign w_evt   = r_btn_evt | {2'b00, w_grav_evt};
    assign w_full  = (r_count == CNT_W'(FIFO_DEPTH));
    assign w_empty = (r_count == '0);

    always_comb begin
        w_push_sel = 3'b000;
        if (!w_full) begin
            if (r_pend[0])      w_push_sel = 3'b001;
            else if (r_pend[1]) w_push_sel = 3'b010;
            else if (r_pend[2]) w_push_sel = 3'b100;
        end
    end

    assign w_push = |w_push_sel;
    assign w_pop  = !final_isMoveOrWriteShape && (r_in_reg[2:0] == 3'b000) && !w_empty;
    assign w_drop = |(w_evt & r_pend & ~w_push_sel);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pend    <= '0;
            r_dropped <= 1'b0;
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_in_reg  <= '0;
        end else begin
            r_pend <= (r_pend & ~w_push_sel) | w_evt;
            if (w_drop) r_dropped <= 1'b1;
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (final_isMoveOrWriteShape) begin
                r_in_reg <= input_reg_update;
            end else if (w_pop) begin
                r_in_reg[2:0] <= r_mem[r_rd_ptr];
            end
        end
    end

    // Queue storage needs no reset: occupancy alone decides what is valid
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= w_push_sel;
    end

    assign in_reg_data   = r_in_reg;
    assign busy          = |r_in_reg[2:0];
    assign fifo_count    = r_count;
    assign event_dropped = r_dropped;

endmodule

// File: tb/tb_input_reg_ctrl.sv
// Scoreboard bench for input_reg_ctrl: expected move flags are queued as stimulus
// is applied and compared when the DUT posts a flag.
module tb_input_reg_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        btn_down = 1'b0;
    logic        btn_left = 1'b0;
    logic        btn_right = 1'b0;
    logic        gravity_en = 1'b0;
    logic        final_isMoveOrWriteShape = 1'b0;
    logic [31:0] input_reg_update = '0;
    logic [31:0] in_reg_data;
    logic        busy;
    logic [2:0]  fifo_count;
    logic        event_dropped;

    int          n_total = 0;
    int          n_bad = 0;
    int          lat;
    logic [2:0]  exp_q [$];

    input_reg_ctrl #(
        .DEBOUNCE_CYCLES(16),
        .GRAVITY_CYCLES (1000),
        .FIFO_DEPTH     (4)
    ) dut (
        .clk                     (clk),
        .rst                     (rst),
        .btn_down                (btn_down),
        .btn_left                (btn_left),
        .btn_right               (btn_right),
        .gravity_en              (gravity_en),
        .final_isMoveOrWriteShape(final_isMoveOrWriteShape),
        .input_reg_update        (input_reg_update),
        .in_reg_data             (in_reg_data),
        .busy                    (busy),
        .fifo_count              (fifo_count),
        .event_dropped           (event_dropped)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // Waits (bounded) for a posted flag, then compares it with the scoreboard head
    task automatic wait_post(input string tag, input int max_cyc, output int cyc);
        logic [2:0] e;
        cyc = 0;
        while (!busy && cyc < max_cyc) begin
            @(negedge clk);
            cyc++;
        end
        if (!busy) begin
            check({tag, "_timeout"}, 32'd0, 32'd1);
        end else if (exp_q.size() == 0) begin
            check({tag, "_unexpected"}, {29'd0, in_reg_data[2:0]}, 32'd0);
        end else begin
            e = exp_q.pop_front();
            check(tag, {29'd0, in_reg_data[2:0]}, {29'd0, e});
        end
    endtask

    task automatic cpu_wb(input logic [31:0] d);
        final_isMoveOrWriteShape = 1'b1;
        input_reg_update = d;
        @(negedge clk);
        final_isMoveOrWriteShape = 1'b0;
        check("wb_load", in_reg_data, d);
    endtask

    task automatic press(input logic [2:0] mask, input int hold, input int gap);
        {btn_right, btn_left, btn_down} = mask;
        repeat (hold) @(negedge clk);
        {btn_right, btn_left, btn_down} = 3'b000;
        repeat (gap) @(negedge clk);
    endtask

    initial begin
        #2 rst = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_data", in_reg_data, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_count", {29'd0, fifo_count}, 32'd0);
        check("rst_drop", {31'd0, event_dropped}, 32'd0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // Gravity: first event posts, second queues behind the busy register
        exp_q.push_back(3'b001);
        gravity_en = 1'b1;
        wait_post("grav_post", 1100, lat);
        check("grav_lat", {31'd0, (lat >= 1000 && lat <= 1004)}, 32'd1);
        check("grav_word", in_reg_data, 32'h1);
        check("grav_busy", {31'd0, busy}, 32'd1);
        exp_q.push_back(3'b001);
        repeat (1005) @(negedge clk);
        check("grav_queue", {29'd0, fifo_count}, 32'd1);
        gravity_en = 1'b0;
        cpu_wb(32'h0);
        wait_post("grav_second", 5, lat);
        check("grav_drain", {29'd0, fifo_count}, 32'd0);

        // Write-back keeps [31:3] and the queued right flag merges in
        exp_q.push_back(3'b100);
        press(3'b100, 22, 22);
        check("right_queued", {29'd0, fifo_count}, 32'd1);
        cpu_wb(32'h0000_2CA8);
        wait_post("right_post", 3, lat);
        check("merge_word", in_reg_data, 32'h0000_2CAC);
        cpu_wb(32'h0);
        repeat (2) @(negedge clk);
        check("idle_word", in_reg_data, 32'd0);

        // Held left button latency, then a short glitch that must be ignored
        exp_q.push_back(3'b010);
        btn_left = 1'b1;
        wait_post("left_post", 30, lat);
        check("left_lat", {31'd0, (lat >= 19 && lat <= 21)}, 32'd1);
        repeat (10) @(negedge clk);
        btn_left = 1'b0;
        repeat (25) @(negedge clk);
        cpu_wb(32'h0);
        btn_left = 1'b1;
        repeat (10) @(negedge clk);
        btn_left = 1'b0;
        repeat (30) @(negedge clk);
        check("glitch_busy", {31'd0, busy}, 32'd0);
        check("glitch_count", {29'd0, fifo_count}, 32'd0);

        // Left and right together: left wins priority
        exp_q.push_back(3'b010);
        exp_q.push_back(3'b100);
        {btn_right, btn_left} = 2'b11;
        wait_post("pair_first", 30, lat);
        repeat (5) @(negedge clk);
        {btn_right, btn_left} = 2'b00;
        repeat (25) @(negedge clk);
        cpu_wb(32'h0);
        wait_post("pair_second", 5, lat);
        cpu_wb(32'h0);
        check("pair_empty", {29'd0, fifo_count}, 32'd0);

        // Fill: one posted, four queued, one pending, then a repeat that is lost
        exp_q.push_back(3'b001);
        exp_q.push_back(3'b010);
        exp_q.push_back(3'b100);
        exp_q.push_back(3'b001);
        exp_q.push_back(3'b010);
        exp_q.push_back(3'b100);
        press(3'b001, 22, 22);
        press(3'b010, 22, 22);
        press(3'b100, 22, 22);
        press(3'b001, 22, 22);
        press(3'b010, 22, 22);
        press(3'b100, 22, 22);
        check("fill_count", {29'd0, fifo_count}, 32'd4);
        check("fill_nodrop", {31'd0, event_dropped}, 32'd0);
        wait_post("fill_first", 1, lat);
        press(3'b100, 22, 22);
        check("drop_flag", {31'd0, event_dropped}, 32'd1);
        check("drop_count", {29'd0, fifo_count}, 32'd4);
        cpu_wb(32'h0);
        wait_post("fill_pop", 3, lat);
        repeat (2) @(negedge clk);
        check("pend_refill", {29'd0, fifo_count}, 32'd4);
        check("drop_sticky", {31'd0, event_dropped}, 32'd1);

        // Asynchronous reset mid-operation wipes everything, queued moves included
        rst = 1'b0;
        #1;
        check("arst_data", in_reg_data, 32'd0);
        check("arst_busy", {31'd0, busy}, 32'd0);
        check("arst_count", {29'd0, fifo_count}, 32'd0);
        check("arst_drop", {31'd0, event_dropped}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        exp_q.delete();
        repeat (40) @(negedge clk);
        check("post_rst_idle", in_reg_data, 32'd0);
        check("post_rst_count", {29'd0, fifo_count}, 32'd0);
        exp_q.push_back(3'b010);
        btn_left = 1'b1;
        wait_post("post_rst_left", 30, lat);
        btn_left = 1'b0;
        check("post_rst_drop", {31'd0, event_dropped}, 32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
